// File: rtl/program_memory_if.sv
// Fetch, control and program-load signals between the program memory and its neighbours.
// "slave" is the memory side; "master" is the controller / instruction-cycle side.
interface program_memory_if #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int INST_DATA_WIDTH = 8
);
  logic [INST_ADDR_WIDTH-1:0] inst_addr;
  logic [INST_DATA_WIDTH-1:0] inst_data;
  logic                       cpu_run;
  logic                       load_start;
  logic                       run_start;
  logic                       halt_req;
  logic                       ld_valid;
  logic [INST_DATA_WIDTH-1:0] ld_data;
  logic                       ld_last;
  logic                       ld_ready;
  logic [INST_ADDR_WIDTH:0]   ld_count;
  logic                       ld_err;

  modport master (
    output inst_addr, load_start, run_start, halt_req, ld_valid, ld_data, ld_last,
    input  inst_data, cpu_run, ld_ready, ld_count, ld_err
  );

  modport slave (
    input  inst_addr, load_start, run_start, halt_req, ld_valid, ld_data, ld_last,
    output inst_data, cpu_run, ld_ready, ld_count, ld_err
  );
endinterface

// File: rtl/program_memory.sv
// Program memory with a HALT/LOAD/RUN controller.
// A streamed program load fills the array from address 0; RUN serves registered instruction fetches.
module program_memory #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int INST_DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  program_memory_if.slave   bus
);
  localparam int DEPTH = 1 << INST_ADDR_WIDTH;
  localparam logic [INST_ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [INST_ADDR_WIDTH:0]   COUNT_ONE = 1;

  typedef enum logic [1:0] {HALT, LOAD, RUN} state_t;

  state_t                     state_reg, state_next;
  logic [INST_ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [INST_ADDR_WIDTH:0]   ld_count_reg, ld_count_next;
  logic                       ld_err_reg, ld_err_next;
  logic                       cpu_run_reg, cpu_run_next;
  logic                       ld_ready_reg, ld_ready_next;
  logic [INST_DATA_WIDTH-1:0] inst_data_reg;
  logic [INST_DATA_WIDTH-1:0] mem [DEPTH];

  logic transfer;
  logic at_last_addr;
  logic enter_load;

  assign transfer     = (state_reg == LOAD) && bus.ld_valid;
  assign at_last_addr = (wr_ptr_reg == '1);
  assign enter_load   = (state_reg != LOAD) && (state_next == LOAD);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= HALT;
      wr_ptr_reg   <= '0;
      ld_count_reg <= '0;
      ld_err_reg   <= 1'b0;
      cpu_run_reg  <= 1'b0;
      ld_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      ld_count_reg <= ld_count_next;
      ld_err_reg   <= ld_err_next;
      cpu_run_reg  <= cpu_run_next;
      ld_ready_reg <= ld_ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALT: begin
        if (bus.load_start)     state_next = LOAD;
        else if (bus.run_start) state_next = RUN;
      end
      LOAD: begin
        // Overflow without ld_last abandons the load rather than running a truncated program.
        if (transfer) begin
          if (bus.ld_last)        state_next = RUN;
          else if (at_last_addr)  state_next = HALT;
        end
      end
      RUN: begin
        if (bus.load_start)     state_next = LOAD;
        else if (bus.halt_req)  state_next = HALT;
      end
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    ld_count_next = ld_count_reg;
    ld_err_next   = ld_err_reg;
    cpu_run_next  = (state_next == RUN);
    ld_ready_next = (state_next == LOAD);
    if (enter_load) begin
      wr_ptr_next   = '0;
      ld_count_next = '0;
      ld_err_next   = 1'b0;
    end else if (transfer) begin
      wr_ptr_next   = wr_ptr_reg + PTR_ONE;
      ld_count_next = ld_count_reg + COUNT_ONE;
      if (!bus.ld_last && at_last_addr) ld_err_next = 1'b1;
    end
  end

  // Array deliberately has no reset so a loaded program survives arst_n.
  always_ff @(posedge clk) begin
    if (transfer) mem[wr_ptr_reg] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                inst_data_reg <= '0;
    else if (state_reg == RUN)  inst_data_reg <= mem[bus.inst_addr];
    else                        inst_data_reg <= '0;
  end

  assign bus.inst_data = inst_data_reg;
  assign bus.cpu_run   = cpu_run_reg;
  assign bus.ld_ready  = ld_ready_reg;
  assign bus.ld_count  = ld_count_reg;
  assign bus.ld_err    = ld_err_reg;
endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the load/run rules.
module tb_program_memory;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  localparam int M_HALT = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  program_memory_if #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW)) bus ();

  program_memory #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endfunction

  // Behavioural model: mode, load bookkeeping and a shadow of the memory contents.
  int m_mode = M_HALT;
  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_err  = 1'b0;
  int m_mem   [DEPTH];
  bit m_known [DEPTH];
  int e_data       = 0;
  bit e_data_known = 1'b1;
  bit e_run        = 1'b0;
  bit e_ready      = 1'b0;
  bit chk_en       = 1'b0;
  int old_mode;

  function automatic void model_start_load();
    m_mode = M_LOAD;
    m_ptr  = 0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endfunction

  always @(negedge arst_n) begin
    m_mode = M_HALT; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
    e_data = 0; e_data_known = 1'b1; e_run = 1'b0; e_ready = 1'b0;
  end

  always @(posedge clk) begin
    if (arst_n) begin
      old_mode = m_mode;
      if (old_mode == M_RUN) begin
        e_data_known = m_known[bus.inst_addr];
        e_data       = m_mem[bus.inst_addr];
      end else begin
        e_data_known = 1'b1;
        e_data       = 0;
      end
      case (old_mode)
        M_HALT: begin
          if (bus.load_start)     model_start_load();
          else if (bus.run_start) m_mode = M_RUN;
        end
        M_LOAD: begin
          if (bus.ld_valid) begin
            m_mem[m_ptr]   = int'(bus.ld_data);
            m_known[m_ptr] = 1'b1;
            m_cnt++;
            if (bus.ld_last) m_mode = M_RUN;
            else if (m_ptr == DEPTH - 1) begin
              m_err = 1'b1; m_mode = M_HALT; m_ptr = 0;
            end else m_ptr++;
          end
        end
        default: begin
          if (bus.load_start)    model_start_load();
          else if (bus.halt_req) m_mode = M_HALT;
        end
      endcase
      e_run   = (m_mode == M_RUN);
      e_ready = (m_mode == M_LOAD);
    end
  end

  always @(negedge clk) begin
    if (chk_en && arst_n) begin
      check("cpu_run", 32'(bus.cpu_run), 32'(e_run));
      check("ld_ready", 32'(bus.ld_ready), 32'(e_ready));
      check("ld_count", 32'(bus.ld_count), 32'(m_cnt));
      check("ld_err", 32'(bus.ld_err), 32'(m_err));
      check("never_both", 32'(bus.cpu_run & bus.ld_ready), 32'(0));
      if (e_data_known) check("inst_data", 32'(bus.inst_data), 32'(e_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_addr = '0; bus.load_start = 1'b0; bus.run_start = 1'b0; bus.halt_req = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] data, input logic last);
    bus.ld_valid = 1'b1; bus.ld_data = data; bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
  endtask

  task automatic pulse_run();
    bus.run_start = 1'b1; tick(); bus.run_start = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    bus.inst_addr = addr; tick();
    check(name, 32'(bus.inst_data), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_data"}, 32'(bus.inst_data), 32'(0));
    check({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'(0));
    check({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'(0));
    check({tag, "_ld_count"}, 32'(bus.ld_count), 32'(0));
    check({tag, "_ld_err"}, 32'(bus.ld_err), 32'(0));
  endtask

  initial begin
    logic [DW-1:0] w3 [3];
    logic [DW-1:0] word;
    idle_inputs();
    tick();
    check_reset_outputs("reset");
    arst_n = 1'b1;
    chk_en = 1'b1;

    // HALT: fetches return NOP whatever the address.
    for (int a = 0; a < 4; a++) begin
      bus.inst_addr = AW'(a); tick();
      check("halt_nop", 32'(bus.inst_data), 32'(0));
      check("halt_cpu_run", 32'(bus.cpu_run), 32'(0));
    end
    $display("txn: halt sweep done");

    // Four-word load then fetch.
    pulse_load();
    check("load_ready", 32'(bus.ld_ready), 32'(1));
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    check("load4_count", 32'(bus.ld_count), 32'(4));
    check("load4_err", 32'(bus.ld_err), 32'(0));
    check("load4_run", 32'(bus.cpu_run), 32'(1));
    check("load4_ready", 32'(bus.ld_ready), 32'(0));
    read_check(8'd2, 8'h33, "load4_fetch2");
    $display("txn: 4-word load done");

    // Three-word load with ld_valid toggling every cycle.
    w3[0] = 8'hAA; w3[1] = 8'hBB; w3[2] = 8'hCC;
    pulse_load();
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = (i % 2 == 0);
      bus.ld_data  = (i % 2 == 0) ? w3[i/2] : 8'hEE;
      bus.ld_last  = (i == 4);
      tick();
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    check("toggle_count", 32'(bus.ld_count), 32'(3));
    read_check(8'd0, 8'hAA, "toggle_fetch0");
    read_check(8'd1, 8'hBB, "toggle_fetch1");
    read_check(8'd2, 8'hCC, "toggle_fetch2");
    read_check(8'd3, 8'h44, "toggle_fetch3_persist");
    $display("txn: stalled 3-word load done");

    // Full-depth load without ld_last overflows back to HALT.
    pulse_load();
    for (int i = 0; i < DEPTH; i++) begin
      word = DW'(i);
      send(word ^ 8'h5A, 1'b0);
    end
    check("ovf_err", 32'(bus.ld_err), 32'(1));
    check("ovf_count", 32'(bus.ld_count), 32'(256));
    check("ovf_cpu_run", 32'(bus.cpu_run), 32'(0));
    check("ovf_ready", 32'(bus.ld_ready), 32'(0));
    pulse_run();
    check("ovf_then_run", 32'(bus.cpu_run), 32'(1));
    check("ovf_err_sticky", 32'(bus.ld_err), 32'(1));
    read_check(8'd255, 8'hA5, "ovf_fetch255");
    read_check(8'd0, 8'h5A, "ovf_fetch0");
    $display("txn: overflow load done");

    // halt_req and load_start together in RUN: load wins.
    bus.halt_req = 1'b1; bus.load_start = 1'b1; tick();
    bus.halt_req = 1'b0; bus.load_start = 1'b0;
    check("prio_ready", 32'(bus.ld_ready), 32'(1));
    check("prio_err", 32'(bus.ld_err), 32'(0));
    check("prio_count", 32'(bus.ld_count), 32'(0));
    $display("txn: halt+load priority done");

    // Reset after 2 of 5 words.
    send(8'hC1, 1'b0); send(8'hC2, 1'b0);
    check("abort_count", 32'(bus.ld_count), 32'(2));
    arst_n = 1'b0;
    #2;
    check_reset_outputs("abort");
    tick();
    arst_n = 1'b1;
    check_reset_outputs("abort_hold");
    pulse_run();
    check("abort_run", 32'(bus.cpu_run), 32'(1));
    read_check(8'd0, 8'hC1, "abort_fetch0");
    read_check(8'd1, 8'hC2, "abort_fetch1");
    read_check(8'd2, 8'h58, "abort_fetch2_persist");
    $display("txn: reset mid-load done");

    // Random traffic checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      bus.load_start = ($urandom_range(19) == 0);
      bus.run_start  = ($urandom_range(15) == 0);
      bus.halt_req   = ($urandom_range(31) == 0);
      bus.ld_valid   = ($urandom_range(9) < 6);
      bus.ld_last    = ($urandom_range(15) == 0);
      bus.ld_data    = DW'($urandom);
      bus.inst_addr  = AW'($urandom);
      if ($urandom_range(499) == 0) begin
        arst_n = 1'b0; tick(); arst_n = 1'b1;
        $display("txn: random reset at cycle %0d", c);
      end else begin
        tick();
      end
    end
    idle_inputs();
    tick();
    $display("txn: random traffic done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
